// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
//   Shared definitions for the PC sequencer slice: PC width, FSM state
//   type, redirect-kind type and a word-alignment helper.
package pc_sequencer_pkg;

  localparam int unsigned PC_W = 32;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    BR   = 2'd1,
    J    = 2'd2,
    JR   = 2'd3
  } redir_kind_e;

  // Clear the two byte-offset bits of an address.
  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return a & ~(PC_W'(3));
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if
//   Instruction-fetch handshake between the PC sequencer and instruction
//   memory.
//   imem_req   : fetch request (sequencer -> memory)
//   imem_addr  : fetch byte address, equal to the current PC
//   imem_ack   : memory has returned the word for imem_addr
//   inst_valid : one-cycle pulse on an accepted fetch (req & ack)
//   Modports: master = sequencer side, slave = memory side.
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic            inst_valid;

  modport master (output imem_req, output imem_addr, output inst_valid,
                  input  imem_ack);
  modport slave  (input  imem_req, input  imem_addr, input  inst_valid,
                  output imem_ack);
endinterface

// File: rtl/pc_sequencer_target_gen.sv
// pc_target_gen
//   Combinational branch / jump target computation.
//   pc_plus4_i  : address of the sequential successor of the current PC
//   br_imm_i    : signed branch word offset
//   j_idx_i     : jump instruction index field
//   br_target_o : pc_plus4 + sign_extend(br_imm) * 4, modulo 2^32
//   j_target_o  : {pc_plus4[31:28], j_idx, 2'b00}
module pc_target_gen
  import pc_sequencer_pkg::*;
(
  input  logic [PC_W-1:0] pc_plus4_i,
  input  logic [15:0]     br_imm_i,
  input  logic [25:0]     j_idx_i,
  output logic [PC_W-1:0] br_target_o,
  output logic [PC_W-1:0] j_target_o
);

  logic [PC_W-1:0] br_off;

  assign br_off      = {{14{br_imm_i[15]}}, br_imm_i, 2'b00};
  assign br_target_o = pc_plus4_i + br_off;
  assign j_target_o  = {pc_plus4_i[31:28], j_idx_i, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Program-counter sequencer with a BOOT/FETCH/HOLD fetch FSM, a
//   one-entry pending-redirect register and prioritised next-PC select
//   (jr > j > br > sequential).
//   Parameters: RESET_VEC (PC after reset), PC_STEP (sequential step).
//   Ports:
//     clk, rst_n            : clock, asynchronous active-low reset
//     stall                 : hold PC, suppress fetch requests
//     br_valid / br_imm     : taken branch and its signed word offset
//     j_valid / j_idx       : J/JAL and its index field
//     jr_valid / jr_target  : register jump and its byte address
//     imem (master)         : imem_req / imem_addr / imem_ack / inst_valid
//     pc, pc_plus4          : current PC and its sequential successor
//     addr_err              : sticky misaligned-jr flag
//   Build option PC_MISALIGN_CHECK_EN: when defined, a misaligned jr
//   target sets addr_err and the redirect is discarded; when undefined
//   the low target bits are cleared and addr_err is tied low.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int unsigned PC_STEP   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 br_valid,
  input  logic [15:0]          br_imm,
  input  logic                 j_valid,
  input  logic [25:0]          j_idx,
  input  logic                 jr_valid,
  input  logic [PC_W-1:0]      jr_target,
  pc_sequencer_if.master       imem,
  output logic [PC_W-1:0]      pc,
  output logic [PC_W-1:0]      pc_plus4,
  output logic                 addr_err
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  redir_kind_e     pend_kind_q, pend_kind_d;
  logic [PC_W-1:0] pend_tgt_q, pend_tgt_d;

  logic            fetch_req;
  logic            accepted;
  logic [PC_W-1:0] br_target, j_target, jr_eff;
  logic            jr_ok;
  redir_kind_e     cur_kind;
  logic [PC_W-1:0] cur_tgt;

  assign pc_plus4 = pc_q + PC_STEP[PC_W-1:0];
  assign pc       = pc_q;

  pc_target_gen u_target_gen (
    .pc_plus4_i  (pc_plus4),
    .br_imm_i    (br_imm),
    .j_idx_i     (j_idx),
    .br_target_o (br_target),
    .j_target_o  (j_target)
  );

  assign jr_eff = word_align(jr_target);

`ifdef PC_MISALIGN_CHECK_EN
  logic err_q;

  assign jr_ok    = (jr_target[1:0] == 2'b00);
  assign addr_err = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (jr_valid && !jr_ok) begin
      err_q <= 1'b1;
    end
  end
`else
  assign jr_ok    = 1'b1;
  assign addr_err = 1'b0;
`endif

  // Redirect requested this cycle. A rejected (misaligned) jr squashes the
  // whole cycle's redirect so the PC keeps flowing sequentially.
  always_comb begin
    cur_kind = NONE;
    cur_tgt  = pc_plus4;
    if (jr_valid) begin
      if (jr_ok) begin
        cur_kind = JR;
        cur_tgt  = jr_eff;
      end
    end else if (j_valid) begin
      cur_kind = J;
      cur_tgt  = j_target;
    end else if (br_valid) begin
      cur_kind = BR;
      cur_tgt  = br_target;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = FETCH;
      FETCH:   if (stall) state_d = HOLD;
      HOLD:    if (!stall) state_d = FETCH;
      default: state_d = BOOT;
    endcase
  end

  // FSM: outputs. Requests only from FETCH, so ack in BOOT/HOLD is ignored.
  always_comb begin
    fetch_req = (state_q == FETCH) && !stall;
    accepted  = fetch_req && imem.imem_ack;
  end

  assign imem.imem_req   = fetch_req;
  assign imem.imem_addr  = pc_q;
  assign imem.inst_valid = accepted;

  // PC and pending redirect. The pending target is captured at arrival;
  // pc cannot move before it is consumed, so the capture stays correct.
  always_comb begin
    pc_d        = pc_q;
    pend_kind_d = pend_kind_q;
    pend_tgt_d  = pend_tgt_q;
    if (accepted) begin
      if (cur_kind != NONE) begin
        pc_d = cur_tgt;
      end else if (pend_kind_q != NONE) begin
        pc_d = pend_tgt_q;
      end else begin
        pc_d = pc_plus4;
      end
      pend_kind_d = NONE;
    end else if (cur_kind != NONE) begin
      pend_kind_d = cur_kind;
      pend_tgt_d  = cur_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_VEC;
      pend_kind_q <= NONE;
      pend_tgt_q  <= '0;
    end else begin
      pc_q        <= pc_d;
      pend_kind_q <= pend_kind_d;
      pend_tgt_q  <= pend_tgt_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  typedef struct {
    logic        stall;
    logic        br_v;
    logic [15:0] br_imm;
    logic        j_v;
    logic [25:0] j_idx;
    logic        jr_v;
    logic [31:0] jr_t;
    logic        ack;
    logic        exp_req;
    logic        exp_iv;
    logic [31:0] exp_pc;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        err;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [15:0] br_imm = '0;
  logic        j_valid = 1'b0;
  logic [25:0] j_idx = '0;
  logic        jr_valid = 1'b0;
  logic [31:0] jr_target = '0;
  logic [31:0] pc, pc_plus4;
  logic        addr_err;

  pc_sequencer_if imem_if ();

  pc_sequencer #(.RESET_VEC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_imm    (br_imm),
    .j_valid   (j_valid),
    .j_idx     (j_idx),
    .jr_valid  (jr_valid),
    .jr_target (jr_target),
    .imem      (imem_if.master),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];
  sb_t  sb[$];
  logic [31:0] model_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic bv, input logic [15:0] bi,
                              input logic jv, input logic [25:0] ji,
                              input logic rv, input logic [31:0] rt, input logic ak,
                              input logic ereq, input logic eiv, input logic [31:0] epc,
                              input logic eerr);
    vec_t v;
    v.stall = st; v.br_v = bv; v.br_imm = bi; v.j_v = jv; v.j_idx = ji;
    v.jr_v = rv; v.jr_t = rt; v.ack = ak;
    v.exp_req = ereq; v.exp_iv = eiv; v.exp_pc = epc; v.exp_err = eerr;
    return v;
  endfunction

  // Called just after a negedge; returns just after the following negedge.
  task automatic apply(input vec_t v, input int idx);
    sb_t e, got;
    stall = v.stall; br_valid = v.br_v; br_imm = v.br_imm;
    j_valid = v.j_v; j_idx = v.j_idx; jr_valid = v.jr_v; jr_target = v.jr_t;
    imem_if.imem_ack = v.ack;
    #1;
    check($sformatf("v%0d imem_req", idx), {31'b0, imem_if.imem_req}, {31'b0, v.exp_req});
    check($sformatf("v%0d inst_valid", idx), {31'b0, imem_if.inst_valid}, {31'b0, v.exp_iv});
    check($sformatf("v%0d imem_addr", idx), imem_if.imem_addr, model_pc);
    e.pc = v.exp_pc; e.err = v.exp_err;
    sb.push_back(e);
    @(posedge clk); #1;
    got = sb.pop_front();
    check($sformatf("v%0d pc", idx), pc, got.pc);
    check($sformatf("v%0d pc_plus4", idx), pc_plus4, got.pc + 32'd4);
    check($sformatf("v%0d addr_err", idx), {31'b0, addr_err}, {31'b0, got.err});
    model_pc = got.pc;
    @(negedge clk);
  endtask

  initial begin
    logic mis_err;
    logic [31:0] mis_pc;
`ifdef PC_MISALIGN_CHECK_EN
    mis_err = 1'b1; mis_pc = 32'h0000_0004;
`else
    mis_err = 1'b0; mis_pc = 32'h0000_2000;
`endif
    imem_if.imem_ack = 1'b0;
    model_pc = 32'h0;

    //            st bv bi        jv ji         rv rt            ak  req iv pc             err
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    0,32'h0,         1,  0,0, 32'h0,         0)); // BOOT
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    0,32'h0,         1,  1,1, 32'h4,         0));
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    0,32'h0,         1,  1,1, 32'h8,         0));
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    0,32'h0,         1,  1,1, 32'hC,         0));
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    1,32'h1000_0010, 1,  1,1, 32'h1000_0010, 0));
    vecs.push_back(mk(0,0,16'h0,   1,26'h40,   0,32'h0,         1,  1,1, 32'h1000_0100, 0));
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    1,32'h0000_0100, 1,  1,1, 32'h0000_0100, 0));
    vecs.push_back(mk(0,1,16'hFFFF,0,26'h0,    0,32'h0,         1,  1,1, 32'h0000_0100, 0));
    vecs.push_back(mk(0,1,16'hFFFF,1,26'h80,   0,32'h0,         1,  1,1, 32'h0000_0200, 0)); // j beats br
    vecs.push_back(mk(0,1,16'h3,   0,26'h0,    0,32'h0,         0,  1,0, 32'h0000_0200, 0)); // br pending
    vecs.push_back(mk(1,0,16'h0,   0,26'h0,    0,32'h0,         1,  0,0, 32'h0000_0200, 0)); // stall
    vecs.push_back(mk(1,0,16'h0,   0,26'h0,    0,32'h0,         1,  0,0, 32'h0000_0200, 0)); // HOLD
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    0,32'h0,         1,  0,0, 32'h0000_0200, 0)); // HOLD->FETCH
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    0,32'h0,         1,  1,1, 32'h0000_0210, 0)); // pending used
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    0,32'h0,         1,  1,1, 32'h0000_0214, 0));
    vecs.push_back(mk(0,0,16'h0,   1,26'h100,  0,32'h0,         0,  1,0, 32'h0000_0214, 0));
    vecs.push_back(mk(0,1,16'h1,   0,26'h0,    0,32'h0,         0,  1,0, 32'h0000_0214, 0)); // overwrite
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    0,32'h0,         1,  1,1, 32'h0000_021C, 0));
    vecs.push_back(mk(0,0,16'h0,   1,26'h100,  0,32'h0,         0,  1,0, 32'h0000_021C, 0));
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    1,32'h0000_3000, 1,  1,1, 32'h0000_3000, 0)); // same-cycle wins
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    0,32'h0,         1,  1,1, 32'h0000_3004, 0));
    vecs.push_back(mk(1,0,16'h0,   0,26'h0,    0,32'h0,         0,  0,0, 32'h0000_3004, 0));
    vecs.push_back(mk(1,0,16'h0,   0,26'h0,    1,32'h0000_5000, 0,  0,0, 32'h0000_3004, 0)); // redirect in HOLD
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    0,32'h0,         0,  0,0, 32'h0000_3004, 0));
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    0,32'h0,         1,  1,1, 32'h0000_5000, 0));
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    1,32'hFFFF_FFFC, 1,  1,1, 32'hFFFF_FFFC, 0));
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    0,32'h0,         1,  1,1, 32'h0000_0000, 0)); // wrap
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    1,32'h0000_2002, 1,  1,1, mis_pc,        mis_err));
    vecs.push_back(mk(0,0,16'h0,   0,26'h0,    0,32'h0,         1,  1,1, mis_pc + 32'd4, mis_err));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset pc", pc, 32'h0);
    check("reset imem_req", {31'b0, imem_if.imem_req}, 32'h0);
    check("reset inst_valid", {31'b0, imem_if.inst_valid}, 32'h0);
    check("reset addr_err", {31'b0, addr_err}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) apply(vecs[i], i);

    // Reset during a fetch with a redirect pending
    br_valid = 1'b1; br_imm = 16'h0010; imem_if.imem_ack = 1'b0;
    @(negedge clk);
    br_valid = 1'b0;
    #1;
    check("pre-reset imem_req", {31'b0, imem_if.imem_req}, 32'h1);
    imem_if.imem_ack = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset pc", pc, 32'h0);
    check("async reset imem_req", {31'b0, imem_if.imem_req}, 32'h0);
    check("async reset inst_valid", {31'b0, imem_if.inst_valid}, 32'h0);
    check("async reset addr_err", {31'b0, addr_err}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("held reset pc", pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post-reset BOOT imem_req", {31'b0, imem_if.imem_req}, 32'h0);
    @(posedge clk); #1;
    check("post-reset BOOT pc", pc, 32'h0);
    @(negedge clk); #1;
    check("post-reset fetch inst_valid", {31'b0, imem_if.inst_valid}, 32'h1);
    @(posedge clk); #1;
    check("post-reset redirect lost pc", pc, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
